// File: rtl/cfs_cdc_word_rx_if.sv
// Valid/ready word bus leaving the CDC receiver.
// master drives valid/data, slave returns ready.
interface cfs_cdc_word_rx_if #(
  parameter int DATA_WIDTH = 32
) ();
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_ready;

  modport master (
    output out_valid,
    output out_data,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    output out_ready
  );
endinterface

// File: rtl/cfs_cdc_word_rx.sv
// Toggle req/ack CDC word receiver, clk-domain side.
// Optional parity check: define CFS_CDC_WORD_RX_PARITY_EN.
module cfs_cdc_word_rx #(
  parameter int DATA_WIDTH  = 32,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_toggle_async,
  input  logic [DATA_WIDTH-1:0] data_async,
`ifdef CFS_CDC_WORD_RX_PARITY_EN
  input  logic                  parity_async,
  output logic                  parity_err,
`endif
  output logic                  ack_toggle,
  output logic [CNT_WIDTH-1:0]  rx_count,
  cfs_cdc_word_rx_if.master     rx
);

  typedef enum logic {
    IDLE,
    CAPTURE_VALID
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync;
  logic                   req_sync;
  logic                   req_seen;
  logic                   valid_q;
  logic [DATA_WIDTH-1:0]  data_q;

  assign req_sync     = sync[SYNC_STAGES-1];
  assign rx.out_valid = valid_q;
  assign rx.out_data  = data_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], req_toggle_async};
    end
  end

  // data_async is quasi-static: the source holds it until our ack
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      req_seen   <= 1'b0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      ack_toggle <= 1'b0;
      rx_count   <= '0;
`ifdef CFS_CDC_WORD_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_sync != req_seen) begin
            state    <= CAPTURE_VALID;
            req_seen <= req_sync;
            valid_q  <= 1'b1;
            data_q   <= data_async;
`ifdef CFS_CDC_WORD_RX_PARITY_EN
            if (^{data_async, parity_async})
              parity_err <= 1'b1;
`endif
          end
        end
        CAPTURE_VALID: begin
          if (valid_q && rx.out_ready) begin
            state      <= IDLE;
            valid_q    <= 1'b0;
            ack_toggle <= ~ack_toggle;
            rx_count   <= rx_count + CNT_ONE;
          end
        end
        default: begin
          state   <= IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cfs_cdc_word_rx.sv
// Scoreboard bench for cfs_cdc_word_rx.
// Parity checks built when CFS_CDC_WORD_RX_PARITY_EN is defined.
module tb_cfs_cdc_word_rx;
  localparam int DW = 32;
  localparam int CW = 8;
  localparam int NB = 300;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req = 1'b0;
  logic [DW-1:0] data = '0;
  logic          ack;
  logic [CW-1:0] cnt;
`ifdef CFS_CDC_WORD_RX_PARITY_EN
  logic          par = 1'b0;
  logic          perr;
`endif

  cfs_cdc_word_rx_if #(.DATA_WIDTH(DW)) bus ();

  cfs_cdc_word_rx #(
    .DATA_WIDTH (DW),
    .SYNC_STAGES(2),
    .CNT_WIDTH  (CW)
  ) u_dut (
    .clk             (clk),
    .reset           (reset),
    .req_toggle_async(req),
    .data_async      (data),
`ifdef CFS_CDC_WORD_RX_PARITY_EN
    .parity_async    (par),
    .parity_err      (perr),
`endif
    .ack_toggle      (ack),
    .rx_count        (cnt),
    .rx              (bus.master)
  );

  always #5 clk = ~clk;

  int            passed = 0;
  int            total = 0;
  logic [DW-1:0] q[$];
  logic          exp_ack = 1'b0;
  logic [CW-1:0] exp_cnt = '0;
  bit            pend = 1'b0;
  bit            bulk = 1'b0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h",
                  nm, act, exp);
  endtask

  // monitor: pops the scoreboard on every handshake
  always @(negedge clk) begin
    if (reset) begin
      exp_ack = 1'b0;
      exp_cnt = '0;
      pend    = 1'b0;
    end else begin
      if (pend) begin
        chk("sb_ack", 64'(ack), 64'(exp_ack));
        chk("sb_cnt", 64'(cnt), 64'(exp_cnt));
        pend = 1'b0;
      end
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          total++;
          $display("FAIL sb_unexpected: got %0h expected none",
                   bus.out_data);
        end else begin
          chk("sb_data", 64'(bus.out_data), 64'(q.pop_front()));
        end
        exp_ack = ~exp_ack;
        exp_cnt = exp_cnt + 1'b1;
        pend    = 1'b1;
      end
    end
  end

  always @(posedge clk) begin
    if (bulk) begin
      #2;
      bus.out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic send(input logic [DW-1:0] d,
                      input bit badpar);
    int n = 0;
    @(posedge clk); #2;
    while (ack !== req && n < 100) begin
      @(posedge clk); #2;
      n++;
    end
    if (n >= 100) chk("src_timeout", 64'd1, 64'd0);
    data = d;
`ifdef CFS_CDC_WORD_RX_PARITY_EN
    par = (^d) ^ badpar;
`else
    if (badpar) data = d;
`endif
    q.push_back(d);
    req = ~req;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!bus.out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("valid_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_done();
    int n = 0;
    while ((ack !== req || q.size() != 0) && n < 400) begin
      @(posedge clk); #2;
      n++;
    end
    if (n >= 400) chk("done_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    repeat (20) begin
      @(negedge clk);
      chk("rst_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_ack", 64'(ack), 64'd0);
      chk("rst_cnt", 64'(cnt), 64'd0);
    end
`ifdef CFS_CDC_WORD_RX_PARITY_EN
    chk("rst_perr", 64'(perr), 64'd0);
`endif

    // request latency: valid after the third edge
    send(32'hDEADBEEF, 1'b0);
    repeat (3) begin
      @(negedge clk);
      chk("lat_valid_lo", 64'(bus.out_valid), 64'd0);
    end
    @(negedge clk);
    chk("lat_valid_hi", 64'(bus.out_valid), 64'd1);
    chk("lat_data", 64'(bus.out_data), 64'hDEADBEEF);
    @(negedge clk);
    chk("one_ack", 64'(ack), 64'd1);
    chk("one_cnt", 64'(cnt), 64'd1);
    chk("one_valid", 64'(bus.out_valid), 64'd0);

    bus.out_ready = 1'b0;
    send(32'hA5A5A5A5, 1'b0);
    wait_valid();
    repeat (10) begin
      @(negedge clk);
      chk("bp_valid", 64'(bus.out_valid), 64'd1);
      chk("bp_data", 64'(bus.out_data), 64'hA5A5A5A5);
      chk("bp_ack", 64'(ack), 64'd1);
      chk("bp_cnt", 64'(cnt), 64'd1);
    end
    @(posedge clk); #2 bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("bp_ack_after", 64'(ack), 64'd0);
    chk("bp_cnt_after", 64'(cnt), 64'd2);

    send(32'h0BADF00D, 1'b0);
    wait_done();
    @(negedge clk);
    chk("pre_rst_ack", 64'(ack), 64'd1);
    chk("pre_rst_cnt", 64'(cnt), 64'd3);

    // reset while a word is pending
    bus.out_ready = 1'b0;
    send(32'h12345678, 1'b0);
    wait_valid();
    @(negedge clk);
    chk("mid_valid_pre", 64'(bus.out_valid), 64'd1);
    @(posedge clk); #2;
    reset = 1'b1;
    req   = 1'b0;
    q.delete();
    #1;
    chk("mid_valid", 64'(bus.out_valid), 64'd0);
    chk("mid_ack", 64'(ack), 64'd0);
    chk("mid_cnt", 64'(cnt), 64'd0);
    chk("mid_data", 64'(bus.out_data), 64'd0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    repeat (5) @(negedge clk);
    chk("post_valid", 64'(bus.out_valid), 64'd0);

    // bulk toggle-back traffic, counter wraps at 2**CW
    bulk = 1'b1;
    for (int i = 0; i < NB; i++)
      send(32'hC0DE0000 ^ (32'(i) * 32'h9E3779B1), 1'b0);
    wait_done();
    bulk = 1'b0;
    @(posedge clk); #2 bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bulk_cnt", 64'(cnt), 64'd44);
    chk("bulk_ack", 64'(ack), 64'(req));

`ifdef CFS_CDC_WORD_RX_PARITY_EN
    chk("bulk_perr", 64'(perr), 64'd0);
    send(32'h00000001, 1'b1);
    wait_done();
    @(negedge clk);
    chk("par_set", 64'(perr), 64'd1);
    send(32'h00000003, 1'b0);
    wait_done();
    repeat (3) @(negedge clk);
    chk("par_sticky", 64'(perr), 64'd1);
`endif

    repeat (3) @(negedge clk);
    chk("sb_empty", 64'(q.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/cfs_cdc_word_rx.md
# cfs_cdc_word_rx

Destination-side receiver for a toggle-based request/acknowledge word transfer from an unrelated clock domain. It synchronises the incoming request toggle through its own flop chain and detects each toggle. It then captures the quasi-static data word, presents it on a valid/ready interface to downstream logic, and returns an acknowledge toggle to the source domain once the word is consumed. It sits directly behind the asynchronous boundary and in front of any register or FIFO logic in the `clk` domain.

## Interface
- `DATA_WIDTH`, 32, width of transferred word.
- `SYNC_STAGES`, 2, flops in request synchroniser chain; legal range 2..4.
- `CNT_WIDTH`, 16, width of received-word counter.
- `clk`  input  1  destination clock; all logic on rising edge.
- `reset`  input  1  asynchronous, active-high reset; asserts immediately, deasserts synchronously by use.
- `req_toggle_async`  input  1  request toggle from source domain; each level change means one new word.
- `data_async`  input  DATA_WIDTH  source word; held stable by the source from before the request toggle until the acknowledge toggle is seen.
- `ack_toggle`  output  1  acknowledge toggle to source domain; registered, glitch-free.
- `out_valid`  output  1  captured word available.
- `out_data`  output  DATA_WIDTH  captured word.
- `out_ready`  input  1  downstream accepts word.
- `rx_count`  output  CNT_WIDTH  number of words accepted downstream.

## Operation
- Synchroniser: `SYNC_STAGES` flops on `req_toggle_async`; the last stage is `req_sync`.
- `req_seen` register holds the last serviced request level.
- New request: `req_sync != req_seen`.
- FSM states:
  - IDLE → CAPTURE_VALID on new request. On that edge: `out_data <= data_async`, `req_seen <= req_sync`, `out_valid <= 1`.
  - CAPTURE_VALID → IDLE on edge where `out_valid && out_ready`. On that edge: `out_valid <= 0`, `ack_toggle <= ~ack_toggle`, `rx_count <= rx_count + 1`.
- `out_data` is stable while `out_valid` is high; it retains its value in IDLE.
- Request toggle arriving during CAPTURE_VALID (protocol violation): not captured then. It is serviced on the first edge in IDLE, since `req_sync != req_seen` persists. Two toggles in CAPTURE_VALID cancel and are lost.
- `rx_count` wraps from all-ones to 0 with no flag.
- `data_async` is sampled directly with no synchroniser; correctness relies on the source holding it stable.

## Timing
- Reset values: `ack_toggle`=0, `out_valid`=0, `out_data`=0, `rx_count`=0, sync chain=0, `req_seen`=0, state IDLE.
- Request latency: `req_toggle_async` changes with setup met before edge E0; `out_valid` is high after edge E(SYNC_STAGES). With the default this is the third rising edge.
- Acceptance: `ack_toggle` changes after the same edge that samples `out_valid && out_ready`. The earliest same-cycle acceptance is the first cycle `out_valid` is high.
- Minimum spacing between captures is 2 cycles (valid cycle plus one IDLE cycle), independent of source-side round trip.
- `out_ready` is ignored while `out_valid`=0.
- Reset mid-transfer: all state clears immediately and any pending word is dropped. If `req_toggle_async`=1 at reset release, a request is detected after the sync latency; both domains must be reset together.

## Configuration
- `CFS_CDC_WORD_RX_PARITY_EN` defined:
  - Adds input `parity_async` (1 bit, even parity over `data_async`, same hold rules as `data_async`).
  - Adds output `parity_err` (1 bit, sticky, reset 0).
  - On each capture edge, `parity_err` sets if `^{data_async, parity_async}` is 1.
  - The word is still delivered normally.
- Macro undefined: parity ports and logic are absent; behaviour otherwise identical.

## Test plan
- Reset release with `req_toggle_async`=0: hold 20 cycles → `out_valid`=0, `ack_toggle`=0, `rx_count`=0 throughout.
- Single word 0xDEADBEEF, `out_ready`=1: toggle req at E0-setup → `out_valid`=1 with data 0xDEADBEEF after E2, `ack_toggle`=1 after E3, `rx_count`=1.
- Backpressure: `out_ready`=0 for 10 cycles after valid → `out_data` stays 0xA5A5A5A5 and `ack_toggle` stays unchanged. Raise ready → one ack toggle, `rx_count` increments once.
- Toggle-back protocol, 70000 words with model source → data order matches; `rx_count` equals 70000 mod 65536 = 4464.
- Reset mid-transfer: `reset` pulse while `out_valid`=1 → `out_valid`=0, `ack_toggle`=0 after reset assertion edge, no extra `rx_count` increment.
- With `CFS_CDC_WORD_RX_PARITY_EN`: send 0x00000001 with `parity_async`=0 → `parity_err`=1 after capture and stays set; next word 0x00000003 with parity 0 leaves it at 1.
